// File: rtl/ef_uart_rx.sv
// ---------------------------------------------------------------------------
// ef_uart_rx : 16x oversampling UART receiver (8N1-style, DW data bits, LSB
// first, no parity). It feeds the core's RX FIFO: `done` is the FIFO write
// strobe and `rdata` is the FIFO write data. There is no backpressure.
//
// Parameters
//   DW         data bits per frame (5..8)
// Ports
//   clk        bus clock
//   rst_n      asynchronous active-low reset
//   en         receiver enable; 0 aborts any frame and holds the block idle
//   prescale   oversampling tick period minus one, in clk cycles
//   RX         asynchronous serial input, idles high
//   rdata      last correctly framed word
//   done       one-cycle pulse, rdata newly valid
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       receiver not idle
//
// Build option
//   EF_UART_RX_MAJORITY_EN : when defined, each bit is the 2-of-3 majority of
//   the samples on ticks sc==6,7,8 (decision on sc==8). Otherwise a single
//   sample on tick sc==7 is used and no sample storage is built.
// ---------------------------------------------------------------------------
module ef_uart_rx #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [15:0]   prescale,
    input  logic          RX,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          frame_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    localparam logic [2:0] BC_LAST = 3'(DW - 1);

    // -----------------------------------------------------------------------
    // Input synchronizer (both flops reset to the idle level)
    // -----------------------------------------------------------------------
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Tick generator. Compare is equality only, so a prescale lowered below
    // the current count lets pc run through 0xFFFF before the next tick.
    // -----------------------------------------------------------------------
    logic [15:0] pc_q, pc_d;
    logic        tick;

    always_comb begin
        tick = en && (pc_q == prescale);
        if (!en || tick) pc_d = '0;
        else             pc_d = pc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    // -----------------------------------------------------------------------
    // Bit sampling
    // -----------------------------------------------------------------------
    logic [3:0] sc_q, sc_d;
    logic       bit_val;
    logic       dec_pt;

`ifdef EF_UART_RX_MAJORITY_EN
    localparam logic [3:0] D_SC = 4'd8;

    logic smp6_q, smp6_d, smp7_q, smp7_d;

    always_comb begin
        smp6_d = smp6_q;
        smp7_d = smp7_q;
        if (tick && sc_q == 4'd6) smp6_d = rx_s_q;
        if (tick && sc_q == 4'd7) smp7_d = rx_s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp6_q <= 1'b1;
            smp7_q <= 1'b1;
        end else begin
            smp6_q <= smp6_d;
            smp7_q <= smp7_d;
        end
    end

    // Third vote is the live sample on the decision tick itself.
    assign bit_val = (smp6_q & smp7_q) | (smp6_q & rx_s_q) | (smp7_q & rx_s_q);
`else
    localparam logic [3:0] D_SC = 4'd7;

    assign bit_val = rx_s_q;
`endif

    assign dec_pt = tick && (sc_q == D_SC);

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bc_q, bc_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            sc_d    = '0;
            bc_d    = '0;
        end else if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        sc_d    = '0;
                    end
                end

                S_START: begin
                    sc_d = sc_q + 4'd1;
                    if (dec_pt && bit_val) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_d = S_IDLE;
                        sc_d    = '0;
                    end else if (sc_q == 4'd15) begin
                        state_d = S_DATA;
                        bc_d    = '0;
                    end
                end

                S_DATA: begin
                    sc_d = sc_q + 4'd1;
                    if (dec_pt) shift_d = {bit_val, shift_q[DW-1:1]};
                    if (sc_q == 4'd15) begin
                        if (bc_q == BC_LAST) state_d = S_STOP;
                        else                 bc_d    = bc_q + 3'd1;
                    end
                end

                S_STOP: begin
                    sc_d = sc_q + 4'd1;
                    // Leave at mid stop bit so a fast sender's next start
                    // edge is not missed.
                    if (dec_pt) begin
                        sc_d = '0;
                        if (bit_val) begin
                            rdata_d = shift_q;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BRK;
                        end
                    end
                end

                S_BRK: begin
                    // Wait out a break so it reports only one frame error.
                    if (rx_s_q) state_d = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ef_uart_rx.sv
module tb_ef_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] prescale;
    logic        RX;
    logic [7:0]  rdata;
    logic        done;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    ef_uart_rx #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .prescale  (prescale),
        .RX        (RX),
        .rdata     (rdata),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic       fe;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;

`ifdef EF_UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

    function automatic exp_t mk(input logic fe, input logic [7:0] d);
        exp_t e;
        e.fe   = fe;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then return #1 after
    // the next rising edge so the caller can drive inputs.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done || frame_err) begin
            chk("done_fe_exclusive", {31'd0, done & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, done, frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_kind_fe", {31'd0, frame_err}, {31'd0, e.fe});
                chk("out_rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        RX = v;
        repeat (n) cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopv,
                              input int bclk, input int stopclk);
        drive(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(d[i], bclk);
        drive(stopv, stopclk);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) cyc();
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        RX       = 1'b1;
        prescale = 16'd0;
        #23;
        chk("reset_rdata", {24'd0, rdata}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        drive(1'b1, 20);

        // 0xA5 at 16 clk/bit
        sb.push_back(mk(1'b0, 8'hA5));
        send_frame(8'hA5, 1'b1, 16, 16);
        drain(64);
        chk("a5_rdata", {24'd0, rdata}, 32'hA5);

        // 4-clk low glitch on idle line: false start
        b0 = busy_cnt;
        drive(1'b0, 4);
        drive(1'b1, 12);
        chk("false_start_busy_seen", {31'd0, busy_cnt > b0}, 32'd1);
        chk("false_start_busy_clear", {31'd0, busy}, 32'd0);
        chk("false_start_rdata", {24'd0, rdata}, 32'hA5);

        // 0x3C with low stop bit, then a long break
        sb.push_back(mk(1'b1, 8'hA5));
        send_frame(8'h3C, 1'b0, 16, 16);
        drive(1'b0, 40 * 16);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_rdata_kept", {24'd0, rdata}, 32'hA5);
        chk("break_fe_consumed", sb.size(), 32'd0);
        drive(1'b1, 64);
        chk("break_release_idle", {31'd0, busy}, 32'd0);
        sb.push_back(mk(1'b0, 8'h55));
        send_frame(8'h55, 1'b1, 16, 16);
        drain(64);
        chk("after_break_rdata", {24'd0, rdata}, 32'h55);

        // Abort 0x81 in data bit 3 by dropping en
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b0, 8);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        en = 1'b0;
        cyc();
        chk("abort_busy_after", {31'd0, busy}, 32'd0);
        drive(1'b1, 40);
        chk("abort_rdata_kept", {24'd0, rdata}, 32'h55);
        en = 1'b1;
        drive(1'b1, 32);
        sb.push_back(mk(1'b0, 8'h0F));
        send_frame(8'h0F, 1'b1, 16, 16);
        drain(64);
        chk("reenable_rdata", {24'd0, rdata}, 32'h0F);

        // prescale=3: back-to-back 0x00 / 0xFF with short stop bits
        prescale = 16'd3;
        drive(1'b1, 128);
        sb.push_back(mk(1'b0, 8'h00));
        sb.push_back(mk(1'b0, 8'hFF));
        send_frame(8'h00, 1'b1, 64, 62);
        send_frame(8'hFF, 1'b1, 64, 62);
        drive(1'b1, 64);
        drain(256);
        chk("b2b_rdata", {24'd0, rdata}, 32'hFF);

        // Tick-aligned glitch on the decision point of data bit 2 of 0x00.
        // Toggling en zeroes pc so ticks land every 4th edge from here.
        drive(1'b1, 64);
        en = 1'b0;
        cyc();
        en = 1'b1;
        drive(1'b1, 4);
        sb.push_back(mk(1'b0, GLITCH_EXP));
        drive(1'b0, 64);      // start
        drive(1'b0, 64);      // bit 0
        drive(1'b0, 64);      // bit 1
        drive(1'b0, 31);      // bit 2 up to the glitch
        drive(1'b1, 4);       // one-tick glitch
        drive(1'b0, 29);      // rest of bit 2
        drive(1'b0, 64 * 5);  // bits 3..7
        drive(1'b1, 64);      // stop
        drain(128);
        chk("glitch_rdata", {24'd0, rdata}, {24'd0, GLITCH_EXP});
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
